// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time over valid/ready, a programmable
// wait-state delay, then a byte/half/word access on a word-wide RAM and a one-cycle response.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    localparam logic [29:0]   DEPTH_W30 = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Any misalignment, reserved size or out-of-range word index is an error.
    function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
        logic align_bad;
        case (size)
            2'b00:   align_bad = 1'b0;
            2'b01:   align_bad = addr[0];
            2'b10:   align_bad = (addr[1:0] != 2'b00);
            default: align_bad = 1'b1;
        endcase
        return align_bad | (addr[31:2] >= DEPTH_W30);
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic uns, input logic [1:0] lane);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (size)
            2'b00:   result = {{24{~uns & shifted[7]}}, shifted[7:0]};
            2'b01:   result = {{16{~uns & shifted[15]}}, shifted[15:0]};
            2'b10:   result = word;
            default: result = 32'h0000_0000;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            2'b00:   mask = 32'h0000_00FF;
            2'b01:   mask = 32'h0000_FFFF;
            2'b10:   mask = 32'hFFFF_FFFF;
            default: mask = 32'h0000_0000;
        endcase
        mask = mask << {lane, 3'b000};
        data = wdata << {lane, 3'b000};
        return (old_word & ~mask) | (data & mask);
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            req_ready_q, req_ready_d;
    logic            busy_q, busy_d;
    logic            resp_valid_q, resp_valid_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            accept_s;
    logic            commit_s;
    logic            eff_we_s;
    logic [1:0]      eff_size_s;
    logic            eff_uns_s;
    logic [31:0]     eff_addr_s;
    logic [31:0]     eff_wdata_s;
    logic            err_s;
    logic [IW-1:0]   idx_s;
    logic [31:0]     ram_rdata_s;
    logic [31:0]     ram_wdata_s;
    logic            ram_we_s;

    // With zero wait states the access happens on the accept edge, so it must see the live request.
    always_comb begin
        accept_s = (state_q == ST_IDLE) && req_valid;
        if (accept_s) begin
            eff_we_s    = req_we;
            eff_size_s  = req_size;
            eff_uns_s   = req_unsigned;
            eff_addr_s  = req_addr;
            eff_wdata_s = req_wdata;
        end else begin
            eff_we_s    = we_q;
            eff_size_s  = size_q;
            eff_uns_s   = uns_q;
            eff_addr_s  = addr_q;
            eff_wdata_s = wdata_q;
        end
    end

    // Next-state, counter and request-latch logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = {CW{1'b0}};
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d  = ST_RESP;
                        commit_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_RESP;
                    commit_s = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Access datapath and registered-output next values.
    always_comb begin
        err_s        = access_err(eff_size_s, eff_addr_s);
        idx_s        = eff_addr_s[IW+1:2];
        ram_rdata_s  = mem_q[idx_s];
        ram_wdata_s  = store_merge(ram_rdata_s, eff_wdata_s, eff_size_s, eff_addr_s[1:0]);
        ram_we_s     = commit_s && eff_we_s && !err_s;
        resp_valid_d = commit_s;
        resp_err_d   = commit_s && err_s;
        if (commit_s && !err_s && !eff_we_s) begin
            resp_rdata_d = load_extract(ram_rdata_s, eff_size_s, eff_uns_s, eff_addr_s[1:0]);
        end else begin
            resp_rdata_d = 32'h0000_0000;
        end
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CW{1'b0}};
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // RAM keeps its contents through reset; a store is dropped if reset is low at its commit edge.
    always_ff @(posedge clk) begin
        if (ram_we_s && rst) begin
            mem_q[idx_s] <= ram_wdata_s;
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance checked against a byte-level memory
// model, plus a WAIT_CYCLES=0 instance used for streaming/back-to-back behaviour.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_req_valid, a_req_we, a_req_unsigned, a_req_ready;
    logic [1:0]  a_req_size;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic        a_resp_valid, a_resp_err, a_busy;

    logic        b_req_valid, b_req_we, b_req_unsigned, b_req_ready;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic        b_resp_valid, b_resp_err, b_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mdl [0:127];
    logic [31:0] bdat [0:3];

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_size(a_req_size), .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
        .resp_err(a_resp_err), .busy(a_busy)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .resp_err(b_resp_err), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-addressed reference: decides error, applies stores, builds load results.
    function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd);
        int n;
        logic [31:0] v;
        n   = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
        err = (sz == 2'd3) || (addr >= 32'd1024) || ((addr % 32'(n)) != 32'd0);
        rd  = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mdl[addr + 32'(i)] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(mdl[addr + 32'(i)]) << (8*i));
                if (!uns && v[8*n-1]) begin
                    for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
                end
                rd = v;
            end
        end
    endfunction

    task automatic req_a(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input string tag);
        logic        e_err;
        logic [31:0] e_rd;
        bit          seen;
        int          lat;
        model(we, sz, uns, addr, wd, e_err, e_rd);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = we; a_req_size = sz; a_req_unsigned = uns;
        a_req_addr = addr; a_req_wdata = wd;
        check({tag, "/ready"}, 32'(a_req_ready), 32'd1);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        a_req_we = 1'($urandom); a_req_size = 2'($urandom); a_req_unsigned = 1'($urandom);
        a_req_addr = $urandom; a_req_wdata = $urandom;
        seen = 1'b0;
        lat  = 99;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (a_resp_valid) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({tag, "/lat"}, 32'(lat), 32'd2);
        check({tag, "/err"}, 32'(a_resp_err), 32'(e_err));
        check({tag, "/rdata"}, a_resp_rdata, e_rd);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] addr;
        bit          seen;
        rst = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = 2'd0; a_req_unsigned = 1'b0;
        a_req_addr = 32'd0; a_req_wdata = 32'd0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'd0; b_req_unsigned = 1'b0;
        b_req_addr = 32'd0; b_req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("reset/ready", 32'(a_req_ready), 32'd1);
        check("reset/busy", 32'(a_busy), 32'd0);
        check("reset/rvalid", 32'(a_resp_valid), 32'd0);
        check("reset/rdata", a_resp_rdata, 32'd0);
        rst = 1'b1;

        for (int w = 0; w < 32; w++) req_a(1'b1, 2'd2, 1'b0, 32'(w*4), $urandom, "init_sw");

        req_a(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "sw_10");
        req_a(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw_10");
        req_a(1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFFFF80, "sb_13");
        req_a(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "lb_13");
        req_a(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "lbu_13");
        req_a(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw_10b");
        req_a(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "lhu_12");
        req_a(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, "lh_10");

        req_a(1'b1, 2'd1, 1'b0, 32'h21, 32'h0000AAAA, "err_sh21");
        req_a(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, "err_lw22");
        req_a(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, "err_lw400");
        req_a(1'b1, 2'd2, 1'b0, 32'h8000_0020, 32'h55555555, "err_alias");
        req_a(1'b1, 2'd3, 1'b0, 32'h20, 32'h66666666, "err_sz3_st");
        req_a(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, "err_sz3_ld");
        req_a(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "lw_20");

        repeat (80) begin
            sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) addr[0] = 1'b0;
                else if (sz == 2'd2) addr[1:0] = 2'b00;
            end
            if ($urandom_range(0, 11) == 0) addr = 32'd1024 + 32'($urandom_range(0, 60000));
            req_a(1'($urandom), sz, 1'($urandom), addr, $urandom, "rand");
        end

        // Asynchronous reset while the response is on the bus.
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_size = 2'd2; a_req_addr = 32'h10;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst/ready", 32'(a_req_ready), 32'd1);
        check("arst/busy", 32'(a_busy), 32'd0);
        check("arst/rvalid", 32'(a_resp_valid), 32'd0);
        check("arst/rdata", a_resp_rdata, 32'd0);
        check("arst/err", 32'(a_resp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (a_resp_valid) seen = 1'b1;
        end
        check("arst/noresp", 32'(seen), 32'd0);

        // Store abandoned by reset during its wait states.
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_size = 2'd2; a_req_addr = 32'h40;
        a_req_wdata = 32'h12345678;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        @(negedge clk);
        check("abort/busy", 32'(a_busy), 32'd1);
        rst = 1'b0;
        #1 check("abort/busy_rst", 32'(a_busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (a_resp_valid) seen = 1'b1;
        end
        check("abort/noresp", 32'(seen), 32'd0);
        req_a(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, "abort_lw40");

        // Zero-wait instance: fill four words, then stream four loads with valid held high.
        for (int k = 0; k < 4; k++) begin
            bdat[k] = $urandom;
            @(negedge clk);
            b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = 2'd2; b_req_unsigned = 1'b0;
            b_req_addr = 32'(k*4); b_req_wdata = bdat[k];
            @(posedge clk);
            #1 b_req_valid = 1'b0;
            @(negedge clk);
            check("b_sw/rvalid", 32'(b_resp_valid), 32'd1);
            check("b_sw/err", 32'(b_resp_err), 32'd0);
        end
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("strm/ready", 32'(b_req_ready), 32'd1);
            check("strm/idle_rvalid", 32'(b_resp_valid), 32'd0);
            @(posedge clk);
            #1;
            if (k < 3) b_req_addr = 32'((k+1)*4);
            else b_req_valid = 1'b0;
            @(negedge clk);
            check("strm/rvalid", 32'(b_resp_valid), 32'd1);
            check("strm/rdata", b_resp_rdata, bdat[k]);
            check("strm/busy_ready", 32'(b_req_ready), 32'd0);
        end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (b_resp_valid) seen = 1'b1;
        end
        check("strm/no_extra", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
